// File: rtl/rptr_empty.sv
// rptr_empty: async FIFO read pointer, empty/almost-empty, fill level and sticky underflow
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic                rclr_err,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr
);
  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);
  logic [ADDRSIZE:0] rbin, rbinnext, rgraynext, wbin_s, level_next;
  logic              rd_ok;
  for (genvar g = 0; g <= ADDRSIZE; g++) begin : g2b
    assign wbin_s[g] = ^rq2_wptr[ADDRSIZE:g];
  end
  always_comb begin
    rd_ok      = rinc & ~rempty;
    rbinnext   = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    level_next = wbin_s - rbinnext;
  end
  assign raddr = rbin[ADDRSIZE-1:0];
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbinnext;
      rptr       <= rgraynext;
      rempty     <= rgraynext == rq2_wptr;
      raempty    <= level_next <= THRESH;
      rlevel     <= level_next;
      runderflow <= (rinc & rempty) | (runderflow & ~rclr_err);
    end
  end
endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: directed self-checking bench for rptr_empty (ADDRSIZE=4, AEMPTY_THRESH=2)
module tb_rptr_empty;
  logic       rclk = 0, rrst = 1, rinc = 0, rclr_err = 0;
  logic [4:0] rq2_wptr = '0;
  logic       rempty, raempty, runderflow;
  logic [4:0] rlevel, rptr;
  logic [3:0] raddr;
  int checks = 0, errors = 0;
  rptr_empty #(.ADDRSIZE(4), .AEMPTY_THRESH(2)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rclr_err(rclr_err), .rq2_wptr(rq2_wptr),
    .rempty(rempty), .raempty(raempty), .rlevel(rlevel), .runderflow(runderflow),
    .raddr(raddr), .rptr(rptr)
  );
  always #5 rclk = ~rclk;
  task automatic tick;
    @(posedge rclk);
    #1;
  endtask
  task automatic test_reset;
    rrst = 1; rq2_wptr = 5'b00110; rinc = 1; rclr_err = 0;
    tick; tick;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b want 1", rempty); end
    checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL reset_raempty got %b want 1", raempty); end
    checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL reset_rlevel got %0d want 0", rlevel); end
    checks++; if (rptr !== 5'b0) begin errors++; $display("FAIL reset_rptr got %b want 00000", rptr); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr got %0d want 0", raddr); end
    checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL reset_runderflow got %b want 0", runderflow); end
  endtask
  task automatic test_fill;
    rrst = 0; rinc = 0; rq2_wptr = 5'b00010;
    tick;
    checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty got %b want 0", rempty); end
    checks++; if (rlevel !== 5'd3) begin errors++; $display("FAIL fill_rlevel got %0d want 3", rlevel); end
    checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL fill_raempty got %b want 0", raempty); end
  endtask
  task automatic test_read;
    logic [4:0] exp_l;
    logic [3:0] exp_a;
    rinc = 1;
    for (int i = 0; i < 3; i++) begin
      exp_a = i[3:0];
      exp_l = 5'(2 - i);
      checks++; if (raddr !== exp_a) begin errors++; $display("FAIL read_raddr[%0d] got %0d want %0d", i, raddr, exp_a); end
      tick;
      checks++; if (rlevel !== exp_l) begin errors++; $display("FAIL read_rlevel[%0d] got %0d want %0d", i, rlevel, exp_l); end
      checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL read_raempty[%0d] got %b want 1", i, raempty); end
      checks++; if (rempty !== (i == 2)) begin errors++; $display("FAIL read_rempty[%0d] got %b want %b", i, rempty, i == 2); end
    end
    checks++; if (rptr !== 5'b00010) begin errors++; $display("FAIL read_rptr got %b want 00010", rptr); end
  endtask
  task automatic test_underflow;
    rinc = 1;
    tick;
    rinc = 0;
    checks++; if (rptr !== 5'b00010) begin errors++; $display("FAIL uf_rptr got %b want 00010", rptr); end
    checks++; if (raddr !== 4'd3) begin errors++; $display("FAIL uf_raddr got %0d want 3", raddr); end
    checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", runderflow); end
    tick;
    checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_hold got %b want 1", runderflow); end
    rclr_err = 1;
    tick;
    checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", runderflow); end
    rinc = 1;
    tick;
    rinc = 0; rclr_err = 0;
    checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got %b want 1", runderflow); end
    checks++; if (rptr !== 5'b00010) begin errors++; $display("FAIL uf_rptr2 got %b want 00010", rptr); end
  endtask
  task automatic test_wrap;
    logic [4:0] exp_l;
    logic [3:0] exp_a;
    rrst = 1; rinc = 0; rq2_wptr = 5'b11000;
    tick;
    rrst = 0;
    tick;
    checks++; if (rlevel !== 5'd16) begin errors++; $display("FAIL wrap_full_level got %0d want 16", rlevel); end
    checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL wrap_full_rempty got %b want 0", rempty); end
    rinc = 1;
    for (int i = 0; i < 16; i++) begin
      exp_a = i[3:0];
      exp_l = 5'(15 - i);
      checks++; if (raddr !== exp_a) begin errors++; $display("FAIL wrap_raddr[%0d] got %0d want %0d", i, raddr, exp_a); end
      tick;
      checks++; if (rlevel !== exp_l) begin errors++; $display("FAIL wrap_rlevel[%0d] got %0d want %0d", i, rlevel, exp_l); end
    end
    rinc = 0;
    checks++; if (rptr !== 5'b11000) begin errors++; $display("FAIL wrap_rptr got %b want 11000", rptr); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL wrap_raddr_end got %0d want 0", raddr); end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL wrap_rempty got %b want 1", rempty); end
    rq2_wptr = 5'b11110;
    tick;
    checks++; if (rlevel !== 5'd4) begin errors++; $display("FAIL wrap_refill_level got %0d want 4", rlevel); end
    checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL wrap_refill_rempty got %b want 0", rempty); end
    checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL wrap_refill_raempty got %b want 0", raempty); end
  endtask
  task automatic test_simultaneous;
    rinc = 1; rq2_wptr = 5'b11111;
    tick;
    rinc = 0;
    checks++; if (rlevel !== 5'd4) begin errors++; $display("FAIL simul_rlevel got %0d want 4", rlevel); end
    checks++; if (rptr !== 5'b11001) begin errors++; $display("FAIL simul_rptr got %b want 11001", rptr); end
    checks++; if (raddr !== 4'd1) begin errors++; $display("FAIL simul_raddr got %0d want 1", raddr); end
  endtask
  task automatic test_reset_mid;
    rq2_wptr = 5'b11101;
    tick;
    checks++; if (rlevel !== 5'd5) begin errors++; $display("FAIL mid_pre_level got %0d want 5", rlevel); end
    rrst = 1; rinc = 1;
    tick;
    rrst = 0; rinc = 0;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL mid_rempty got %b want 1", rempty); end
    checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL mid_raempty got %b want 1", raempty); end
    checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL mid_rlevel got %0d want 0", rlevel); end
    checks++; if (rptr !== 5'b0) begin errors++; $display("FAIL mid_rptr got %b want 00000", rptr); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL mid_raddr got %0d want 0", raddr); end
    checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL mid_runderflow got %b want 0", runderflow); end
  endtask
  initial begin
    #1;
    test_reset;
    test_fill;
    test_read;
    test_underflow;
    test_wrap;
    test_simultaneous;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
